// File: rtl/uart_loader_pkg.sv
// Shared definitions for the UART program loader: word width, state encoding
// and the default inter-word timeout.
package uart_loader_pkg;

    localparam int unsigned UL_WORD_WIDTH     = 16;
    localparam int unsigned UL_TIMEOUT_CYCLES = 5000000;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_LEN  = 3'd1,
        S_DATA = 3'd2,
        S_CSUM = 3'd3,
        S_DONE = 3'd4,
        S_ERR  = 3'd5
    } loader_state_t;

endpackage

// File: rtl/uart_loader_rise_detect.sv
// Rising-edge detector: one-cycle pulse on each 0->1 transition of the input,
// whether the input is a pulse or a held level.
module rise_detect (
    input  logic clk,
    input  logic rst,
    input  logic in,
    output logic out
);

    logic in_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            in_q <= 1'b0;
        end else begin
            in_q <= in;
        end
    end

    assign out = in & ~in_q;

endmodule

// File: rtl/uart_loader.sv
// Program loader: parses a length/payload/checksum frame of assembled UART words,
// writes the payload to memory and releases the CPU from reset on a clean load.
module uart_loader
    import uart_loader_pkg::*;
#(
    parameter int unsigned WORD_WIDTH     = UL_WORD_WIDTH,
    parameter int unsigned ADDR_WIDTH     = 10,
    parameter int unsigned TIMEOUT_CYCLES = UL_TIMEOUT_CYCLES
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  uart_word_ready,
    input  logic [WORD_WIDTH-1:0] uart_word,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [WORD_WIDTH-1:0] mem_data,
    output logic                  cpu_rst_n,
    output logic                  busy,
    output logic                  done,
    output logic                  err
);

    localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam int unsigned CW = ADDR_WIDTH + 1;
    localparam logic [TW-1:0]         TIMER_LAST = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [WORD_WIDTH-1:0] MAX_LEN    = WORD_WIDTH'(1) << ADDR_WIDTH;

    loader_state_t state, state_next;

    logic                  acc;
    logic                  load_go;
    logic                  timeout;
    logic [TW-1:0]         timer;
    logic [ADDR_WIDTH-1:0] addr;
    logic [CW-1:0]         remaining;
    logic [WORD_WIDTH-1:0] sum;

    rise_detect u_ready_edge (
        .clk (clk),
        .rst (rst),
        .in  (uart_word_ready),
        .out (acc)
    );

    assign timeout = (timer == TIMER_LAST);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // An accept always takes priority over a coincident timer expiry.
    always_comb begin
        state_next = state;
        load_go    = 1'b0;
        case (state)
            S_IDLE, S_DONE, S_ERR: begin
                if (start) begin
                    state_next = S_LEN;
                    load_go    = 1'b1;
                end
            end
            S_LEN: begin
                if (acc) begin
                    if (uart_word == '0)          state_next = S_CSUM;
                    else if (uart_word > MAX_LEN) state_next = S_ERR;
                    else                          state_next = S_DATA;
                end else if (timeout) begin
                    state_next = S_ERR;
                end
            end
            S_DATA: begin
                if (acc) begin
                    if (remaining == CW'(1)) state_next = S_CSUM;
                end else if (timeout) begin
                    state_next = S_ERR;
                end
            end
            S_CSUM: begin
                if (acc)          state_next = (uart_word == sum) ? S_DONE : S_ERR;
                else if (timeout) state_next = S_ERR;
            end
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_data  <= '0;
            timer     <= '0;
            addr      <= '0;
            remaining <= '0;
            sum       <= '0;
        end else begin
            mem_we <= 1'b0;
            if (load_go) begin
                timer     <= '0;
                addr      <= '0;
                remaining <= '0;
                sum       <= '0;
            end else if (busy) begin
                timer <= acc ? '0 : timer + TW'(1);
                if (acc && state == S_LEN) begin
                    remaining <= CW'(uart_word);
                end
                if (acc && state == S_DATA) begin
                    mem_we    <= 1'b1;
                    mem_addr  <= addr;
                    mem_data  <= uart_word;
                    addr      <= addr + ADDR_WIDTH'(1);
                    sum       <= sum + uart_word;
                    remaining <= remaining - CW'(1);
                end
            end
        end
    end

    assign busy      = (state == S_LEN) || (state == S_DATA) || (state == S_CSUM);
    assign done      = (state == S_DONE);
    assign err       = (state == S_ERR);
    assign cpu_rst_n = (state == S_DONE);

endmodule

// File: tb/tb_uart_loader.sv
// Directed self-checking bench for uart_loader with a shortened timeout.
module tb_uart_loader;

    localparam int unsigned TO = 100;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic        uart_word_ready = 1'b0;
    logic [15:0] uart_word = '0;
    logic        mem_we;
    logic [9:0]  mem_addr;
    logic [15:0] mem_data;
    logic        cpu_rst_n, busy, done, err;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int wr_count = 0;
    int dbl_we   = 0;
    logic we_prev = 1'b0;

    uart_loader #(
        .WORD_WIDTH     (16),
        .ADDR_WIDTH     (10),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .start           (start),
        .uart_word_ready (uart_word_ready),
        .uart_word       (uart_word),
        .mem_we          (mem_we),
        .mem_addr        (mem_addr),
        .mem_data        (mem_data),
        .cpu_rst_n       (cpu_rst_n),
        .busy            (busy),
        .done            (done),
        .err             (err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (mem_we) wr_count++;
        if (mem_we && we_prev) dbl_we++;
        we_prev = mem_we;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=0x%0h exp=0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic check_status(input string tag, input logic b, input logic d, input logic e);
        check({tag, ".busy"}, {31'b0, busy}, {31'b0, b});
        check({tag, ".done"}, {31'b0, done}, {31'b0, d});
        check({tag, ".err"},  {31'b0, err},  {31'b0, e});
        check({tag, ".cpu_rst_n"}, {31'b0, cpu_rst_n}, {31'b0, d});
    endtask

    task automatic pulse_start();
        @(posedge clk);
        #1 start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    // Presents one word; after the accepting edge, checks whether a write appeared.
    task automatic send_word(input logic [15:0] w, input int unsigned hold,
                             input logic exp_we, input logic [9:0] exp_addr);
        @(posedge clk);
        #1;
        uart_word       = w;
        uart_word_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("mem_we", {31'b0, mem_we}, {31'b0, exp_we});
        if (exp_we) begin
            check("mem_addr", {22'b0, mem_addr}, {22'b0, exp_addr});
            check("mem_data", {16'b0, mem_data}, {16'b0, w});
        end
        repeat (hold) @(posedge clk);
        #1 uart_word_ready = 1'b0;
    endtask

    int w0, acc_cyc, waited;
    logic [15:0] s;

    initial begin
        // Reset state
        #12;
        check_status("reset", 1'b0, 1'b0, 1'b0);
        check("reset.mem_we",   {31'b0, mem_we}, 32'd0);
        check("reset.mem_addr", {22'b0, mem_addr}, 32'd0);
        check("reset.mem_data", {16'b0, mem_data}, 32'd0);
        @(negedge clk) rst = 1'b1;

        // Word in IDLE without start is ignored
        send_word(16'h0003, 0, 1'b0, 10'd0);
        @(negedge clk);
        check_status("idle_word", 1'b0, 1'b0, 1'b0);

        // Normal load
        w0 = wr_count;
        pulse_start();
        @(negedge clk);
        check_status("normal.start", 1'b1, 1'b0, 1'b0);
        send_word(16'h0003, 0, 1'b0, 10'd0);
        send_word(16'h1111, 0, 1'b1, 10'd0);
        send_word(16'h2222, 0, 1'b1, 10'd1);
        send_word(16'h3333, 0, 1'b1, 10'd2);
        send_word(16'h6666, 0, 1'b0, 10'd0);
        check_status("normal.end", 1'b0, 1'b1, 1'b0);
        check("normal.writes", wr_count - w0, 32'd3);

        // Bad checksum from DONE; restart drops cpu_rst_n again
        w0 = wr_count;
        pulse_start();
        @(negedge clk);
        check_status("bad.start", 1'b1, 1'b0, 1'b0);
        send_word(16'h0003, 0, 1'b0, 10'd0);
        send_word(16'h1111, 0, 1'b1, 10'd0);
        send_word(16'h2222, 0, 1'b1, 10'd1);
        send_word(16'h3333, 0, 1'b1, 10'd2);
        send_word(16'h6667, 0, 1'b0, 10'd0);
        check_status("bad.end", 1'b0, 1'b0, 1'b1);
        check("bad.writes", wr_count - w0, 32'd3);

        // Recovery from ERR; checksum wraps modulo 2^16 (0x8000+0x8001 = 0x0001)
        pulse_start();
        send_word(16'h0002, 0, 1'b0, 10'd0);
        send_word(16'h8000, 0, 1'b1, 10'd0);
        send_word(16'h8001, 0, 1'b1, 10'd1);
        send_word(16'h0001, 0, 1'b0, 10'd0);
        check_status("recover.end", 1'b0, 1'b1, 1'b0);

        // Empty frame; a word arriving together with start is ignored
        w0 = wr_count;
        @(posedge clk);
        #1;
        start = 1'b1;
        uart_word = 16'h0005;
        uart_word_ready = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        uart_word_ready = 1'b0;
        send_word(16'h0000, 0, 1'b0, 10'd0);
        send_word(16'h0000, 0, 1'b0, 10'd0);
        check_status("empty.end", 1'b0, 1'b1, 1'b0);
        check("empty.writes", wr_count - w0, 32'd0);

        // Oversize length
        w0 = wr_count;
        pulse_start();
        send_word(16'h0401, 0, 1'b0, 10'd0);
        check_status("oversize", 1'b0, 1'b0, 1'b1);
        repeat (3) @(negedge clk);
        check("oversize.writes", wr_count - w0, 32'd0);

        // Held ready produces a single write
        w0 = wr_count;
        pulse_start();
        send_word(16'h0001, 0, 1'b0, 10'd0);
        send_word(16'hABCD, 9, 1'b1, 10'd0);
        send_word(16'hABCD, 0, 1'b0, 10'd0);
        check_status("held.end", 1'b0, 1'b1, 1'b0);
        check("held.writes", wr_count - w0, 32'd1);

        // Start mid-DATA is ignored
        w0 = wr_count;
        pulse_start();
        send_word(16'h0003, 0, 1'b0, 10'd0);
        send_word(16'h0010, 0, 1'b1, 10'd0);
        pulse_start();
        send_word(16'h0020, 0, 1'b1, 10'd1);
        send_word(16'h0030, 0, 1'b1, 10'd2);
        send_word(16'h0060, 0, 1'b0, 10'd0);
        check_status("middata.end", 1'b0, 1'b1, 1'b0);
        check("middata.writes", wr_count - w0, 32'd3);

        // Timeout: err exactly TO cycles after the last accept
        pulse_start();
        send_word(16'h0002, 0, 1'b0, 10'd0);
        send_word(16'h4242, 0, 1'b1, 10'd0);
        acc_cyc = cyc;
        waited  = 0;
        while (!err && waited < 3 * TO) begin
            @(negedge clk);
            waited++;
        end
        check("timeout.err", {31'b0, err}, 32'd1);
        check("timeout.cycles", cyc - acc_cyc, TO);
        check_status("timeout.end", 1'b0, 1'b0, 1'b1);

        // Reset mid-load
        pulse_start();
        send_word(16'h0003, 0, 1'b0, 10'd0);
        send_word(16'h0101, 0, 1'b1, 10'd0);
        send_word(16'h0202, 0, 1'b1, 10'd1);
        #2 rst = 1'b0;
        #1;
        check_status("midrst", 1'b0, 1'b0, 1'b0);
        check("midrst.mem_we",   {31'b0, mem_we}, 32'd0);
        check("midrst.mem_addr", {22'b0, mem_addr}, 32'd0);
        check("midrst.mem_data", {16'b0, mem_data}, 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check_status("midrst.idle", 1'b0, 1'b0, 1'b0);
        pulse_start();
        send_word(16'h0003, 0, 1'b0, 10'd0);
        send_word(16'h1111, 0, 1'b1, 10'd0);
        send_word(16'h2222, 0, 1'b1, 10'd1);
        send_word(16'h3333, 0, 1'b1, 10'd2);
        send_word(16'h6666, 0, 1'b0, 10'd0);
        check_status("midrst.reload", 1'b0, 1'b1, 1'b0);

        // Full-size frame: last write at 1023, no write after address wraps
        w0 = wr_count;
        s  = '0;
        pulse_start();
        send_word(16'h0400, 0, 1'b0, 10'd0);
        for (int i = 0; i < 1024; i++) begin
            logic [15:0] v;
            v = 16'(i * 37 + 5);
            s = s + v;
            send_word(v, 0, 1'b1, 10'(i));
        end
        send_word(s, 0, 1'b0, 10'd0);
        check_status("full.end", 1'b0, 1'b1, 1'b0);
        check("full.writes", wr_count - w0, 32'd1024);
        check("full.last_addr", {22'b0, mem_addr}, 32'd1023);

        check("we_never_back_to_back", dbl_we, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_loader.md
Name: uart_loader

Overview:
- Sequences the UART word assembler during program download.
- Consumes the assembled 16-bit word stream (ready strobe plus word) and parses a frame of length, payload and checksum.
- Writes each payload word into instruction/data memory at consecutive addresses.
- Holds the CPU in reset until a load completes cleanly; reports busy, done and error status.

Parameters:
- WORD_WIDTH, 16 (`WORD_WIDTH), width of uart_word, memory data and checksum.
- ADDR_WIDTH, 10, memory address width; maximum payload is 2^ADDR_WIDTH words.
- TIMEOUT_CYCLES, 5000000, idle clocks allowed between words inside a frame before abort.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-low reset.
- start  in  1  load request; level sampled each clock, acted on in IDLE/DONE/ERR.
- uart_word_ready  in  1  word-valid from the assembler; may be a pulse or held level, only the rising edge counts.
- uart_word  in  WORD_WIDTH  assembled word, stable while uart_word_ready is high.
- mem_we  out  1  one-cycle memory write strobe.
- mem_addr  out  ADDR_WIDTH  write address.
- mem_data  out  WORD_WIDTH  write data.
- cpu_rst_n  out  1  active-low CPU reset; low whenever a load is not complete.
- busy  out  1  high in LEN, DATA or CSUM.
- done  out  1  high in DONE.
- err  out  1  high in ERR.

Behaviour:
- Reset (async, rst=0): state=IDLE; mem_we=0, mem_addr=0, mem_data=0, cpu_rst_n=0, busy=0, done=0, err=0; counters, checksum and edge register cleared.
- Word accept: acc = uart_word_ready & ~ready_q, where ready_q is registered uart_word_ready. Exactly one accept per rising edge. uart_word is sampled in the accept cycle.
- States:
  - IDLE: start=1 -> LEN (clear addr, count, sum, timer). Accepts are ignored, including an accept in the same cycle as start.
  - LEN: accept -> len=uart_word.
    - len=0 -> CSUM.
    - len>2^ADDR_WIDTH -> ERR.
    - else -> DATA with remaining=len.
  - DATA: each accept:
    - next cycle mem_we=1, mem_addr=addr, mem_data=word (1-cycle latency, registered outputs).
    - addr++, sum+=word modulo 2^WORD_WIDTH, remaining--.
    - remaining reaching 0 -> CSUM.
  - CSUM: accept -> word==sum ? DONE : ERR.
  - DONE: cpu_rst_n=1, done=1. start=1 -> LEN, which drives cpu_rst_n=0 again.
  - ERR: cpu_rst_n=0, err=1. Only start=1 -> LEN (err cleared).
- Timeout: in LEN/DATA/CSUM a timer counts clocks since the last accept (or since entry). Reaching TIMEOUT_CYCLES -> ERR.
  - An accept in the same cycle as timer expiry wins: the word is processed and the timer is cleared.
- Address wrap: with len=2^ADDR_WIDTH, the final write lands at address 2^ADDR_WIDTH-1; addr wraps to 0 afterwards with no further write.
- mem_we is never high outside the cycle after a DATA accept, and is never high for two consecutive cycles. Consecutive accepts are at least 2 cycles apart due to edge detection.
- start while busy is ignored.
- Reset mid-load: returns to IDLE immediately; a partial memory image stays, cpu_rst_n=0.
- busy/done/err are decoded from registered state; at most one is high at a time.

Decomposition:
- Shared defs header holds: WORD_WIDTH, the loader state encoding (IDLE=0, LEN=1, DATA=2, CSUM=3, DONE=4, ERR=5, 3-bit), and the default TIMEOUT_CYCLES constant.
- One sub-module, rise_detect: clk, rst, in, out pulse. Reused for uart_word_ready and available to other strobe consumers.
- Counter, checksum and FSM stay in uart_loader.

Test Plan:
- Normal load:
  - Stimulus: start, then words 0x0003, 0x1111, 0x2222, 0x3333, checksum 0x6666.
  - Required: three writes (0,0x1111), (1,0x2222), (2,0x3333), each 1 cycle after accept; then done=1, cpu_rst_n=1, err=0.
- Bad checksum:
  - Stimulus: same frame with checksum 0x6667.
  - Required: all 3 writes occur, then err=1, cpu_rst_n=0, done=0. A following start plus a good frame reaches done=1.
- Empty and oversize length:
  - Stimulus: len 0x0000 followed by checksum 0x0000.
  - Required: done=1 with no mem_we.
  - Stimulus: len 0x0401 (ADDR_WIDTH=10).
  - Required: err=1 with no mem_we.
- Held ready and timeout:
  - Stimulus: uart_word_ready held high for 10 cycles on one word.
  - Required: a single write.
  - Stimulus: TIMEOUT_CYCLES=100, len 2, one data word, then silence.
  - Required: err=1 exactly 100 cycles after the last accept.
- Ignored inputs:
  - Stimulus: a word in IDLE without start.
  - Required: no state change.
  - Stimulus: start pulsed mid-DATA.
  - Required: ignored, frame completes normally.
- Reset mid-load:
  - Stimulus: rst=0 after 2 of 3 data words, then release.
  - Required: state=IDLE, all outputs at reset values, cpu_rst_n=0; a fresh full load then succeeds.
